avmm_vec_mem_responder: RTL and testbench

- Avalon-MM pipelined-read slave with an internal word RAM. It is the responder for the vector dot-product cores' master port, and stands in for the SDRAM controller in simulation and on-chip builds.
- Accepts single-word writes and (burst) reads. Returns read data in order, after a programmable minimum latency, with backpressure via waitrequest.
- The HPS/test side preloads vectors through the same port before start.

---
 rtl/avmm_vec_mem_responder_pkg.sv | 32 +++
 rtl/avmm_vec_mem_responder_if.sv | 25 ++
 rtl/avmm_vec_mem_responder_sync_fifo.sv | 58 +++++
 rtl/avmm_vec_mem_responder.sv | 154 +++++++++++++++
 tb/tb_avmm_vec_mem_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_vec_mem_responder_pkg.sv
// Shared types and helpers for the Avalon-MM vector memory responder.
// The read command record is sized for RAMs of up to 64K words.
package avmm_vec_pkg;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned WORD_ADDR_W = 16;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [7:0]             beats;
        logic [15:0]            stamp;
    } rd_cmd_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BEAT = 1'b1
    } resp_state_t;

    // Zero means a single beat; anything past the limit is cut down to the limit.
    function automatic logic [7:0] clamp_burst(input logic [7:0] bc, input int unsigned max_burst);
        logic [7:0] lim;
        lim = max_burst[7:0];
        if (bc == 8'd0) begin
            return 8'd1;
        end else if (32'(bc) > max_burst) begin
            return lim;
        end else begin
            return bc;
        end
    endfunction

endpackage

// File: rtl/avmm_vec_mem_responder_if.sv
// Avalon-MM pipelined-read bus between a vector core master and the memory responder.
interface avmm_vec_mem_responder_if;
    import avmm_vec_pkg::*;

    logic [31:0]           avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [31:0]           avs_writedata;
    logic [WORD_BYTES-1:0] avs_byteenable;
    logic [7:0]            avs_burstcount;
    logic                  avs_waitrequest;
    logic [31:0]           avs_readdata;
    logic                  avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );

endinterface

// File: rtl/avmm_vec_mem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may happen in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q + PtrW'(do_push);
        rptr_d  = rptr_q + PtrW'(do_pop);
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/avmm_vec_mem_responder.sv
// Avalon-MM slave with internal word RAM, in-order read responses after a minimum latency.
// Optional random stalls/bubbles are enabled by defining AVMM_STALL_INJECT_EN.
module avmm_vec_mem_responder
    import avmm_vec_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned MAX_PENDING  = 8,
    parameter int unsigned MAX_BURST    = 16
) (
    input  logic                          clock,
    input  logic                          resetn,
    avmm_vec_mem_responder_if.slave       avs,
    output logic                          protocol_err,
    output logic [$clog2(MAX_PENDING):0]  pending
);

    localparam int unsigned WordW = $clog2(DEPTH);

    logic [31:0]      ram_q [DEPTH];
    logic [15:0]      cyc_q;
    logic             err_q, err_d;
    resp_state_t      state_q, state_d;
    logic [WordW-1:0] addr_q, addr_d;
    logic [7:0]       beats_q, beats_d;

    logic [WordW-1:0] word_idx;
    logic             fifo_full, fifo_empty, fifo_pop;
    rd_cmd_t          push_cmd, head;
    logic             rd_acc, wr_acc, stall, bubble, head_elig, beat_valid;
    logic             unused_bits;

    assign word_idx    = avs.avs_address[WordW+1:2];
    assign unused_bits = ^{avs.avs_address[31:WordW+2], avs.avs_address[1:0], head.addr};

`ifdef AVMM_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
    assign stall  = (lfsr_q[1:0] == 2'b00);
    assign bubble = (lfsr_q[3:2] == 2'b00);
`else
    assign stall  = 1'b0;
    assign bubble = 1'b0;
`endif

    // Writes are only held off by reset or injected stalls, never by a full queue.
    assign avs.avs_waitrequest = !resetn || (avs.avs_read && fifo_full) || stall;

    assign rd_acc = avs.avs_read && !avs.avs_waitrequest;
    assign wr_acc = avs.avs_write && !avs.avs_read && !avs.avs_waitrequest;

    assign push_cmd = '{addr:  WORD_ADDR_W'(word_idx),
                        beats: clamp_burst(avs.avs_burstcount, MAX_BURST),
                        stamp: cyc_q};

    sync_fifo #(
        .Width($bits(rd_cmd_t)),
        .Depth(MAX_PENDING)
    ) u_cmd_fifo (
        .clk_i  (clock),
        .rst_ni (resetn),
        .push_i (rd_acc),
        .pop_i  (fifo_pop),
        .wdata_i(push_cmd),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(pending)
    );

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (avs.avs_byteenable[i]) begin
                    ram_q[word_idx][8*i +: 8] <= avs.avs_writedata[8*i +: 8];
                end
            end
        end
    end

    // Stamp difference is modulo 2^16, so counter wrap is harmless.
    assign head_elig  = !fifo_empty && ((cyc_q - head.stamp) >= 16'(READ_LATENCY));
    assign beat_valid = (state_q == BEAT) && !bubble;

    assign avs.avs_readdatavalid = beat_valid;
    assign avs.avs_readdata      = beat_valid ? ram_q[addr_q] : 32'd0;

    always_comb begin
        err_d = err_q;
        if ((avs.avs_read && avs.avs_write && !avs.avs_waitrequest) ||
            (wr_acc && avs.avs_burstcount > 8'd1)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (head_elig) begin
                    fifo_pop = 1'b1;
                    addr_d   = head.addr[WordW-1:0];
                    beats_d  = head.beats;
                    state_d  = BEAT;
                end
            end
            BEAT: begin
                if (!bubble) begin
                    addr_d  = addr_q + 1'b1;
                    beats_d = beats_q - 8'd1;
                    if (beats_q == 8'd1) begin
                        // Chain straight into the next eligible command with no idle cycle.
                        if (head_elig) begin
                            fifo_pop = 1'b1;
                            addr_d   = head.addr[WordW-1:0];
                            beats_d  = head.beats;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cyc_q   <= '0;
            err_q   <= 1'b0;
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            cyc_q   <= cyc_q + 16'd1;
            err_q   <= err_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    assign protocol_err = err_q;

endmodule

// File: tb/tb_avmm_vec_mem_responder.sv
// Directed self-checking bench for avmm_vec_mem_responder (default build, no stall injection).
module tb_avmm_vec_mem_responder;
    import avmm_vec_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       protocol_err;
    logic [3:0] pending;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [31:0] beat_data[$];
    int          beat_cyc[$];

    avmm_vec_mem_responder_if bus ();

    avmm_vec_mem_responder #(
        .DEPTH       (1024),
        .READ_LATENCY(4),
        .MAX_PENDING (8),
        .MAX_BURST   (16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .avs         (bus.slave),
        .protocol_err(protocol_err),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.avs_readdatavalid === 1'b1) begin
            beat_data.push_back(bus.avs_readdata);
            beat_cyc.push_back(cyc);
        end
    end

    task automatic drive_idle();
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = 32'd0;
        bus.avs_writedata  = 32'd0;
        bus.avs_byteenable = 4'h0;
        bus.avs_burstcount = 8'd0;
    endtask

    // Starts just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic [7:0] bc,
                         output int acc_cyc);
        int n;
        n = 0;
        bus.avs_read       = rd;
        bus.avs_write      = wr;
        bus.avs_address    = addr;
        bus.avs_writedata  = wd;
        bus.avs_byteenable = be;
        bus.avs_burstcount = bc;
        @(negedge clock);
        while (bus.avs_waitrequest !== 1'b0 && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL issue_timeout: waitrequest=%b still high, required 0 within 200 cycles",
                     bus.avs_waitrequest);
        end
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        drive_idle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        int a;
        issue(1'b0, 1'b1, addr, wd, 4'hF, 8'd1, a);
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int k;
        k = 0;
        while (beat_data.size() < n && k < 300) begin
            @(negedge clock);
            #1;
            k++;
        end
        ok = (beat_data.size() >= n);
    endtask

    task automatic clear_beats();
        beat_data.delete();
        beat_cyc.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL reset_waitrequest: got %b, required 1", bus.avs_waitrequest);
        end
        checks++;
        if (bus.avs_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL reset_rdv: got %b, required 0", bus.avs_readdatavalid);
        end
        checks++;
        if (bus.avs_readdata !== 32'd0) begin
            errors++; $display("FAIL reset_readdata: got %h, required 0", bus.avs_readdata);
        end
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++; $display("FAIL reset_protocol_err: got %b, required 0", protocol_err);
        end
        checks++;
        if (pending !== 4'd0) begin
            errors++; $display("FAIL reset_pending: got %0d, required 0", pending);
        end
        #2 resetn = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.avs_waitrequest !== 1'b0) begin
            errors++; $display("FAIL post_reset_waitrequest: got %b, required 0", bus.avs_waitrequest);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic_latency();
        int acc;
        bit ok;
        wr(32'h0, 32'h0000_0003);
        wr(32'h4, 32'hFFFF_FFFE);
        clear_beats();
        issue(1'b1, 1'b0, 32'h0, 32'd0, 4'h0, 8'd2, acc);
        wait_beats(2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL basic_beats: got %0d beats, required 2", beat_data.size());
        end else begin
            checks++;
            if (beat_data[0] !== 32'h0000_0003) begin
                errors++; $display("FAIL basic_data0: got %h, required 00000003", beat_data[0]);
            end
            checks++;
            if (beat_data[1] !== 32'hFFFF_FFFE) begin
                errors++; $display("FAIL basic_data1: got %h, required fffffffe", beat_data[1]);
            end
            checks++;
            if (beat_cyc[0] - acc !== 4) begin
                errors++; $display("FAIL basic_latency: got %0d cycles, required 4", beat_cyc[0] - acc);
            end
            checks++;
            if (beat_cyc[1] - beat_cyc[0] !== 1) begin
                errors++; $display("FAIL basic_consecutive: got gap %0d, required 1",
                                   beat_cyc[1] - beat_cyc[0]);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_byteenable();
        int acc;
        bit ok;
        wr(32'd200, 32'hAABB_CCDD);
        issue(1'b0, 1'b1, 32'd200, 32'h1122_3344, 4'b0101, 8'd1, acc);
        clear_beats();
        issue(1'b1, 1'b0, 32'd200, 32'd0, 4'h0, 8'd1, acc);
        wait_beats(1, ok);
        checks++;
        if (!ok || beat_data[0] !== 32'hAA22_CC44) begin
            errors++; $display("FAIL byteenable_merge: got %h (beats %0d), required aa22cc44",
                               ok ? beat_data[0] : 32'hx, beat_data.size());
        end
        @(posedge clock);
        #1;
    endtask

    // A 16-beat burst ahead keeps the engine busy so eight singles fill the queue.
    task automatic test_queue_full();
        int acc;
        int n;
        bit ok;
        logic [31:0] exp;
        for (int i = 16; i < 32; i++) wr(32'(i * 4), 32'hC0DE_0000 + 32'(i));
        for (int i = 40; i < 49; i++) wr(32'(i * 4), 32'hC0DE_0000 + 32'(i));
        clear_beats();
        issue(1'b1, 1'b0, 32'd64, 32'd0, 4'h0, 8'd16, acc);
        for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 32'((40 + i) * 4), 32'd0, 4'h0, 8'd1, acc);
        bus.avs_read       = 1'b1;
        bus.avs_address    = 32'(48 * 4);
        bus.avs_burstcount = 8'd1;
        @(negedge clock);
        checks++;
        if (bus.avs_waitrequest !== 1'b1) begin
            errors++; $display("FAIL full_waitrequest: got %b, required 1", bus.avs_waitrequest);
        end
        checks++;
        if (pending !== 4'd8) begin
            errors++; $display("FAIL full_pending: got %0d, required 8", pending);
        end
        n = 0;
        while (bus.avs_waitrequest !== 1'b0 && n < 200) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (n >= 200) begin
            errors++; $display("FAIL full_release: waitrequest stuck at %b, required 0", bus.avs_waitrequest);
        end
        @(posedge clock);
        #1;
        drive_idle();
        wait_beats(25, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL full_beats: got %0d beats, required 25", beat_data.size());
        end else begin
            for (int i = 0; i < 25; i++) begin
                exp = (i < 16) ? 32'hC0DE_0000 + 32'(16 + i) : 32'hC0DE_0000 + 32'(40 + i - 16);
                checks++;
                if (beat_data[i] !== exp) begin
                    errors++; $display("FAIL full_order[%0d]: got %h, required %h", i, beat_data[i], exp);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (pending !== 4'd0) begin
            errors++; $display("FAIL full_drained: pending got %0d, required 0", pending);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wrap();
        int acc;
        bit ok;
        wr(32'hFFC, 32'hA1A1_A1A1);
        wr(32'h000, 32'hA2A2_A2A2);
        wr(32'h004, 32'hA3A3_A3A3);
        clear_beats();
        issue(1'b1, 1'b0, 32'hFFC, 32'd0, 4'h0, 8'd3, acc);
        wait_beats(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL wrap_beats: got %0d beats, required 3", beat_data.size());
        end else begin
            checks++;
            if (beat_data[0] !== 32'hA1A1_A1A1) begin
                errors++; $display("FAIL wrap_word1023: got %h, required a1a1a1a1", beat_data[0]);
            end
            checks++;
            if (beat_data[1] !== 32'hA2A2_A2A2) begin
                errors++; $display("FAIL wrap_word0: got %h, required a2a2a2a2", beat_data[1]);
            end
            checks++;
            if (beat_data[2] !== 32'hA3A3_A3A3) begin
                errors++; $display("FAIL wrap_word1: got %h, required a3a3a3a3", beat_data[2]);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_protocol_err();
        int acc;
        bit ok;
        wr(32'd1200, 32'h1111_1111);
        wr(32'd1204, 32'h2222_2222);
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++; $display("FAIL perr_initial: got %b, required 0", protocol_err);
        end
        issue(1'b0, 1'b1, 32'd1200, 32'hDEAD_BEEF, 4'hF, 8'd2, acc);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++; $display("FAIL perr_write_burst: got %b, required 1", protocol_err);
        end
        clear_beats();
        issue(1'b1, 1'b0, 32'd1200, 32'd0, 4'h0, 8'd2, acc);
        wait_beats(2, ok);
        checks++;
        if (!ok || beat_data[0] !== 32'hDEAD_BEEF || beat_data[1] !== 32'h2222_2222) begin
            errors++; $display("FAIL perr_first_word_only: got %h %h, required deadbeef 22222222",
                               ok ? beat_data[0] : 32'hx, ok ? beat_data[1] : 32'hx);
        end
        @(posedge clock);
        #1 resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++; $display("FAIL perr_reset_clear: got %b, required 0", protocol_err);
        end
        #2 resetn = 1'b1;
        @(posedge clock);
        #1;
        clear_beats();
        issue(1'b1, 1'b1, 32'd1204, 32'h5555_5555, 4'hF, 8'd1, acc);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++; $display("FAIL perr_rd_wr: got %b, required 1", protocol_err);
        end
        wait_beats(1, ok);
        checks++;
        if (!ok || beat_data[0] !== 32'h2222_2222) begin
            errors++; $display("FAIL perr_write_dropped: got %h, required 22222222",
                               ok ? beat_data[0] : 32'hx);
        end
        repeat (10) @(negedge clock);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++; $display("FAIL perr_sticky: got %b, required 1", protocol_err);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        bit ok;
        for (int i = 0; i < 4; i++) wr(32'((100 + i) * 4), 32'h5A00_0000 + 32'(i));
        clear_beats();
        issue(1'b1, 1'b0, 32'd400, 32'd0, 4'h0, 8'd4, acc);
        issue(1'b1, 1'b0, 32'd800, 32'd0, 4'h0, 8'd1, acc);
        wait_beats(2, ok);
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (bus.avs_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL midreset_rdv: got %b, required 0", bus.avs_readdatavalid);
        end
        checks++;
        if (pending !== 4'd0) begin
            errors++; $display("FAIL midreset_pending: got %0d, required 0", pending);
        end
        checks++;
        if (!ok || beat_data[0] !== 32'h5A00_0000 || beat_data[1] !== 32'h5A00_0001) begin
            errors++; $display("FAIL midreset_early_beats: got %0d beats, required 5a000000 5a000001",
                               beat_data.size());
        end
        @(negedge clock);
        #2 resetn = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (beat_data.size() !== 2) begin
            errors++; $display("FAIL midreset_discard: got %0d beats, required 2", beat_data.size());
        end
        @(posedge clock);
        #1;
        clear_beats();
        issue(1'b1, 1'b0, 32'd412, 32'd0, 4'h0, 8'd1, acc);
        wait_beats(1, ok);
        checks++;
        if (!ok || beat_data[0] !== 32'h5A00_0003) begin
            errors++; $display("FAIL midreset_ram_kept: got %h, required 5a000003",
                               ok ? beat_data[0] : 32'hx);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_basic_latency();
        test_byteenable();
        test_queue_full();
        test_wrap();
        test_protocol_err();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
